// File: rtl/arb_mux.sv
// arb_mux: N_CH-input arbiter feeding a single registered output stage.
//
// Each cycle the first valid channel found from ptr upward (wrapping) is
// granted. Its word is captured into the output register whenever that
// register is empty or being drained in the same cycle. RR=1 rotates ptr
// past the last grant; RR=0 keeps ptr at 0, so channel 0 has the highest
// priority.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   per-channel valid
//   in_data    channel k at bits [k*W +: W]
//   in_ready   per-channel accept (combinational, one-hot or zero)
//   out_valid  output register holds a word
//   out_data   registered selected word
//   out_sel    index of the channel that supplied out_data
//   out_ready  downstream accept
module arb_mux #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 4,
    parameter bit          RR   = 1'b1,
    localparam int unsigned SW  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_sel,
    input  logic              out_ready
);

    logic [SW-1:0] ptr_q, ptr_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_sel_q, out_sel_d;

    logic          found;
    logic [SW-1:0] gnt;
    logic [SW:0]   idx_wide;
    logic [SW-1:0] idx;
    logic [W-1:0]  gnt_data;
    logic          load;

    // Rotating search: visit ptr, ptr+1, ... modulo N_CH; first valid wins.
    always_comb begin
        found    = 1'b0;
        gnt      = '0;
        idx_wide = '0;
        idx      = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx_wide = {1'b0, ptr_q} + (SW+1)'(i);
            if (idx_wide >= (SW+1)'(N_CH)) begin
                idx_wide = idx_wide - (SW+1)'(N_CH);
            end
            idx = idx_wide[SW-1:0];
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    // Constant-index mux: only the granted slice can reach gnt_data, so
    // unknowns on other channels never propagate.
    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt == SW'(k)) begin
                gnt_data = in_data[k*W +: W];
            end
        end
    end

    // Reset gates load so in_ready stays low during a reset cycle.
    assign load = !rst && found && (!out_valid_q || out_ready);

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N_CH; k++) begin
            in_ready[k] = load && (gnt == SW'(k));
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_sel_d   = gnt;
            if (RR) begin
                ptr_d = (gnt == SW'(N_CH - 1)) ? '0 : gnt + SW'(1);
            end else begin
                ptr_d = '0;
            end
        end else if (out_ready) begin
            // Drained with nothing to replace it; data/sel keep last values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Testbench for arb_mux: a round-robin and a fixed-priority instance share
// the same stimulus; a behavioural model checks both every cycle, and
// directed scenarios pin literal expectations.
module tb_arb_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_valid = '0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b1;

    logic [3:0]  rdy0, rdy1;
    logic        ov0, ov1;
    logic [3:0]  od0, od1;
    logic [1:0]  os0, os1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    arb_mux #(.N_CH(4), .W(4), .RR(1'b1)) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_sel(os0),
        .out_ready(out_ready)
    );

    arb_mux #(.N_CH(4), .W(4), .RR(1'b0)) u_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_sel(os1),
        .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state per instance: index 0 = round-robin, 1 = fixed priority.
    bit         m_valid[2];
    logic [3:0] m_data[2];
    int         m_sel[2];
    int         m_ptr[2];
    bit         n_valid[2];
    logic [3:0] n_data[2];
    int         n_sel[2];
    int         n_ptr[2];

    int         g, k;
    bit         ld;
    logic [3:0] exp_rdy;
    logic [3:0] act_rdy, act_data;
    logic       act_valid;
    logic [1:0] act_sel;

    always @(negedge clk) begin
        for (int r = 0; r < 2; r++) begin
            g = -1;
            for (int i = 0; i < 4; i++) begin
                k = (m_ptr[r] + i) % 4;
                if (g < 0 && in_valid[k[1:0]]) g = k;
            end
            ld      = !rst && (g >= 0) && (!m_valid[r] || out_ready);
            exp_rdy = ld ? 4'(1 << g) : 4'b0;

            act_rdy   = (r == 0) ? rdy0 : rdy1;
            act_valid = (r == 0) ? ov0 : ov1;
            act_data  = (r == 0) ? od0 : od1;
            act_sel   = (r == 0) ? os0 : os1;
            if (chk_en) begin
                chk($sformatf("m%0d in_ready", r), 32'(act_rdy), 32'(exp_rdy));
                chk($sformatf("m%0d out_valid", r), 32'(act_valid), 32'(m_valid[r]));
                chk($sformatf("m%0d out_data", r), 32'(act_data), 32'(m_data[r]));
                chk($sformatf("m%0d out_sel", r), 32'(act_sel), 32'(m_sel[r]));
            end

            n_valid[r] = m_valid[r];
            n_data[r]  = m_data[r];
            n_sel[r]   = m_sel[r];
            n_ptr[r]   = m_ptr[r];
            if (rst) begin
                n_valid[r] = 1'b0;
                n_data[r]  = '0;
                n_sel[r]   = 0;
                n_ptr[r]   = 0;
            end else if (ld) begin
                n_valid[r] = 1'b1;
                n_data[r]  = in_data[g*4 +: 4];
                n_sel[r]   = g;
                n_ptr[r]   = (r == 0) ? (g + 1) % 4 : 0;
            end else if (out_ready) begin
                n_valid[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            m_valid[r] <= n_valid[r];
            m_data[r]  <= n_data[r];
            m_sel[r]   <= n_sel[r];
            m_ptr[r]   <= n_ptr[r];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst      = 1'b1;
        in_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset out_valid", 32'(ov0), 32'd0);
        chk("reset out_data", 32'(od0), 32'd0);
        chk("reset out_sel", 32'(os0), 32'd0);

        // Basic select: only channel 2 valid.
        in_data   = 16'hDCBA;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #3 chk("basic in_ready", 32'(rdy0), 32'h4);
        tick();
        chk("basic out_valid", 32'(ov0), 32'd1);
        chk("basic out_data", 32'(od0), 32'hC);
        chk("basic out_sel", 32'(os0), 32'd2);

        // Round-robin fairness with wrap; fixed priority stays on ch0.
        reset_pulse();
        in_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr seq out_sel", 32'(os0), 32'(i % 4));
            chk("rr seq out_data", 32'(od0), 32'(10 + i % 4));
            chk("fp seq out_sel", 32'(os1), 32'd0);
        end

        // Backpressure: hold word 7, ch1 waits, then loads 10.
        reset_pulse();
        in_data  = 16'h00A7;
        in_valid = 4'b0001;
        tick();
        chk("bp first data", 32'(od0), 32'd7);
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        repeat (3) begin
            #3 chk("bp in_ready", 32'(rdy0), 32'd0);
            tick();
            chk("bp hold data", 32'(od0), 32'd7);
            chk("bp hold valid", 32'(ov0), 32'd1);
        end
        out_ready = 1'b1;
        #3 chk("bp release in_ready", 32'(rdy0), 32'h2);
        tick();
        chk("bp next data", 32'(od0), 32'd10);
        chk("bp next sel", 32'(os0), 32'd1);
        in_valid = '0;
        tick();
        chk("drain out_valid", 32'(ov0), 32'd0);
        chk("drain keeps data", 32'(od0), 32'd10);
        chk("drain keeps sel", 32'(os0), 32'd1);

        // X isolation on unselected channel 3.
        reset_pulse();
        in_data  = {4'bxxxx, 4'd3, 4'd10, 4'd7};
        in_valid = 4'b0100;
        tick();
        chk("xiso out_data", 32'(od0), 32'd3);
        chk("xiso no x", 32'($isunknown({ov0, od0, os0, rdy0})), 32'd0);
        in_data  = '0;
        in_valid = '0;
        tick();

        // Fixed priority: 1010 held, ch1 always wins.
        in_data  = 16'h4321;
        in_valid = 4'b1010;
        repeat (5) begin
            #3 chk("fp in_ready", 32'(rdy1), 32'h2);
            tick();
            chk("fp out_sel", 32'(os1), 32'd1);
            chk("fp out_data", 32'(od1), 32'd2);
        end
        in_valid = '0;
        tick();

        // Reset while a word is held.
        in_data   = {4'd8, 4'd6, 4'd9, 4'd5};
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        tick();
        chk("rst-mid load", 32'(od0), 32'd5);
        in_valid = '0;
        tick();
        chk("rst-mid held", 32'(od0), 32'd5);
        rst      = 1'b1;
        in_valid = 4'hF;
        #3 chk("rst in_ready", 32'(rdy0), 32'd0);
        tick();
        chk("rst out_valid", 32'(ov0), 32'd0);
        chk("rst out_data", 32'(od0), 32'd0);
        chk("rst out_sel", 32'(os0), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post-rst sel", 32'(os0), 32'd0);
        chk("post-rst data", 32'(od0), 32'd5);

        // Random traffic checked by the model.
        repeat (3000) begin
            rst       = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
